// File: rtl/rgb_pkg.sv
// Shared constants for the RGB PWM block: duty width default, LED count and
// the bit positions of the red/green/blue fields in a 12-bit pattern word.
package rgb_pkg;

    localparam int unsigned PWM_W_DEF = 8;
    localparam int unsigned LED_CNT   = 4;
    localparam int unsigned CH_W      = 3 * LED_CNT;

    // Pattern word order is {r3..r0, g3..g0, b3..b0}
    localparam int unsigned R_LSB = 2 * LED_CNT;
    localparam int unsigned G_LSB = LED_CNT;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [LED_CNT-1:0] r;
        logic [LED_CNT-1:0] g;
        logic [LED_CNT-1:0] b;
    } rgb_ptn_t;

    function automatic logic [CH_W-1:0] gate_ptn(input logic [CH_W-1:0] ptn,
                                                 input logic            on);
        logic [CH_W-1:0] res;
        res = '0;
        res[R_LSB +: LED_CNT] = ptn[R_LSB +: LED_CNT] & {LED_CNT{on}};
        res[G_LSB +: LED_CNT] = ptn[G_LSB +: LED_CNT] & {LED_CNT{on}};
        res[B_LSB +: LED_CNT] = ptn[B_LSB +: LED_CNT] & {LED_CNT{on}};
        return res;
    endfunction

endpackage

// File: rtl/m_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count with a
// one-cycle tick before wrapping.
module m_tick_gen #(
    parameter int unsigned DIV = 390
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/m_rgb_pwm.sv
// 12-channel RGB PWM driver with a one-deep pattern/duty buffer that is only
// promoted to the active setting at frame boundaries, so output never glitches.
module m_rgb_pwm
    import rgb_pkg::*;
#(
    parameter int unsigned PRESC_DIV = 390,
    parameter int unsigned PWM_W     = PWM_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ptn_valid,
    output logic             ptn_ready,
    input  logic [CH_W-1:0]  ptn_data,
    input  logic [PWM_W-1:0] ptn_duty,
    output logic [CH_W-1:0]  led_out,
    output logic             frame_pulse
);

    logic             w_tick;
    logic             w_boundary;
    logic             w_xfer;
    logic             w_on;

    logic [PWM_W-1:0] r_phase;
    logic [CH_W-1:0]  r_pend_ptn;
    logic [PWM_W-1:0] r_pend_duty;
    logic             r_pend_full;
    logic [CH_W-1:0]  r_act_ptn;
    logic [PWM_W-1:0] r_act_duty;
    logic [CH_W-1:0]  r_led;
    logic             r_frame;

    m_tick_gen #(
        .DIV (PRESC_DIV)
    ) u_tick_gen (
        .i_clk  (CLK),
        .i_rst  (RST),
        .o_tick (w_tick)
    );

    assign w_boundary = w_tick && (r_phase == '1);
    assign ptn_ready  = !r_pend_full;
    assign w_xfer     = ptn_valid && !r_pend_full;
    assign w_on       = (r_phase < r_act_duty);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_phase <= '0;
        end else if (w_tick) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // A transfer needs pend_full=0 and a promotion needs pend_full=1, so the
    // two branches never collide; a pair taken in a boundary cycle waits a frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pend_ptn  <= '0;
            r_pend_duty <= '0;
            r_pend_full <= 1'b0;
            r_act_ptn   <= '0;
            r_act_duty  <= '0;
        end else if (w_xfer) begin
            r_pend_ptn  <= ptn_data;
            r_pend_duty <= ptn_duty;
            r_pend_full <= 1'b1;
        end else if (w_boundary && r_pend_full) begin
            r_act_ptn   <= r_pend_ptn;
            r_act_duty  <= r_pend_duty;
            r_pend_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_led   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_led   <= gate_ptn(r_act_ptn, w_on);
            r_frame <= w_boundary;
        end
    end

    assign led_out     = r_led;
    assign frame_pulse = r_frame;

endmodule

// File: tb/tb_m_rgb_pwm.sv
// Randomized self-checking bench for m_rgb_pwm against a frame-level model
// derived from elapsed clock count since reset release.
module tb_m_rgb_pwm;

    localparam int unsigned PD    = 2;
    localparam int unsigned PW    = 8;
    localparam int          FRAME = PD * 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ptn_valid = 1'b0;
    logic        ptn_ready;
    logic [11:0] ptn_data = 12'h000;
    logic [7:0]  ptn_duty = 8'h00;
    logic [11:0] led_out;
    logic        frame_pulse;

    m_rgb_pwm #(
        .PRESC_DIV (PD),
        .PWM_W     (PW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ptn_valid   (ptn_valid),
        .ptn_ready   (ptn_ready),
        .ptn_data    (ptn_data),
        .ptn_duty    (ptn_duty),
        .led_out     (led_out),
        .frame_pulse (frame_pulse)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: k counts clock edges since reset release
    int          k;
    logic [11:0] m_pend_ptn, m_act_ptn;
    logic [7:0]  m_pend_duty, m_act_duty;
    logic        m_pend_full;
    int          acc_k [3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        k           = 0;
        m_pend_ptn  = '0;
        m_pend_duty = '0;
        m_pend_full = 1'b0;
        m_act_ptn   = '0;
        m_act_duty  = '0;
    endtask

    // Called at posedge+1; drives one cycle, advances the model, checks outputs.
    task automatic step(input logic v, input logic [11:0] d, input logic [7:0] du);
        int          ph;
        logic        bnd;
        logic        xfer;
        logic [11:0] exp_led;
        ptn_valid = v;
        ptn_data  = d;
        ptn_duty  = du;
        k++;
        ph      = ((k - 1) / PD) % 256;
        bnd     = ((k % FRAME) == 0);
        exp_led = (ph < int'(m_act_duty)) ? m_act_ptn : 12'h000;
        xfer    = v && !m_pend_full;
        if (bnd && m_pend_full) begin
            m_act_ptn   = m_pend_ptn;
            m_act_duty  = m_pend_duty;
            m_pend_full = 1'b0;
        end
        if (xfer) begin
            m_pend_ptn  = d;
            m_pend_duty = du;
            m_pend_full = 1'b1;
        end
        @(posedge CLK);
        #1;
        check_val("led", 32'(led_out), 32'(exp_led));
        check_val("frame", 32'(frame_pulse), 32'(bnd));
        check_val("ready", 32'(ptn_ready), 32'(!m_pend_full));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'($urandom), 8'($urandom));
    endtask

    // Holds valid until the DUT shows ready; returns the edge index of acceptance.
    task automatic send(input logic [11:0] d, input logic [7:0] du, output int acc);
        logic rdy;
        acc = -1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            rdy = ptn_ready;
            step(1'b1, d, du);
            if (rdy) begin
                acc = k;
                break;
            end
        end
        ptn_valid = 1'b0;
        if (acc < 0) check_val("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_boundary();
        int i;
        for (i = 0; i < 2 * FRAME; i++) begin
            idle(1);
            if ((k % FRAME) == 0) break;
        end
        if (i == 2 * FRAME) check_val("bnd_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_frame(input logic [11:0] val, output int cnt);
        cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            idle(1);
            if (led_out == val) cnt++;
        end
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        ptn_valid = 1'b1;
        ptn_data  = 12'($urandom);
        #1;
        check_val("rst_led", 32'(led_out), 32'h000);
        check_val("rst_frame", 32'(frame_pulse), 32'd0);
        check_val("rst_ready", 32'(ptn_ready), 32'd1);
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_hold_ready", 32'(ptn_ready), 32'd1);
        RST       = 1'b0;
        ptn_valid = 1'b0;
        model_reset();
    endtask

    initial begin
        int acc;
        int cnt;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_val("por_led", 32'(led_out), 32'h000);
        check_val("por_ready", 32'(ptn_ready), 32'd1);
        RST = 1'b0;

        idle(FRAME + 40);

        send(12'hFFF, 8'd128, acc);
        wait_boundary();
        count_frame(12'hFFF, cnt);
        check_val("half_duty_on", 32'(cnt), 32'd256);
        idle(FRAME / 2);

        do_reset();
        idle(FRAME + 10);

        send(12'($urandom), 8'd0, acc);
        wait_boundary();
        count_frame(12'h000, cnt);
        check_val("duty0_off", 32'(cnt), 32'(FRAME));

        send(12'h0F0, 8'd255, acc);
        wait_boundary();
        count_frame(12'h000, cnt);
        check_val("duty255_off", 32'(cnt), 32'd2);

        for (int i = 0; i < 3; i++) begin
            send(12'($urandom), 8'($urandom), acc);
            acc_k[i] = acc;
        end
        check_val("b2b_second_slot", 32'(acc_k[1] % FRAME), 32'd1);
        check_val("b2b_third_gap", 32'(acc_k[2] - acc_k[1]), 32'(FRAME));
        wait_boundary();
        idle(20);

        for (int i = 0; i < 2 * FRAME; i++) begin
            if (((k + 1) % FRAME) == 0 && !m_pend_full) break;
            idle(1);
        end
        send(12'($urandom), 8'($urandom), acc);
        check_val("bnd_accept_slot", 32'(acc % FRAME), 32'd0);
        send(12'($urandom), 8'($urandom), acc);
        check_val("bnd_accept_apply", 32'(acc % FRAME), 32'd1);

        for (int i = 0; i < 3 * FRAME; i++) begin
            step(($urandom_range(0, 7) == 0), 12'($urandom), 8'($urandom));
        end
        ptn_valid = 1'b0;

        send(12'($urandom), 8'($urandom), acc);
        idle(50);
        do_reset();
        idle(FRAME + 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m_rgb_pwm.md
M_RGB_PWM -- requirements
Module: m_rgb_pwm

Interface
REQ-001 SHALL have parameter PRESC_DIV, default 390; clocks per PWM tick (100 MHz / 390 / 256 ≈ 1 kHz frame).
REQ-002 SHALL have parameter PWM_W, default 8; width of phase counter and duty value.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ptn_valid  in  1  upstream offers a pattern/duty pair.
REQ-006 SHALL have port ptn_ready  out  1  block can accept a pair this cycle.
REQ-007 SHALL have port ptn_data  in  12  on/off pattern, order {r3,r2,r1,r0,g3,g2,g1,g0,b3,b2,b1,b0}.
REQ-008 SHALL have port ptn_duty  in  PWM_W  brightness applied to all enabled channels.
REQ-009 SHALL have port led_out  out  12  PWM-modulated LED drive, same bit order as ptn_data.
REQ-010 SHALL have port frame_pulse  out  1  one-cycle pulse when a new frame begins.

Function
REQ-011 SHALL run prescaler 0..PRESC_DIV-1; tick asserted in the cycle it equals PRESC_DIV-1, then wraps to 0.
REQ-012 SHALL advance phase counter by 1 on each tick, wrapping 2^PWM_W-1 -> 0 without saturation.
REQ-013 SHALL define boundary = tick && phase == 2^PWM_W-1.
REQ-014 SHALL hold one pending slot (pend_ptn, pend_duty, pend_full); ptn_ready = !pend_full, combinational.
REQ-015 SHALL transfer when ptn_valid && ptn_ready: pending slot loaded, pend_full set next cycle.
REQ-016 SHALL ignore ptn_data/ptn_duty when no transfer occurs; upstream may change them freely while ptn_valid is low.
REQ-017 SHALL, at boundary with pend_full=1, copy pending into active (act_ptn, act_duty) and clear pend_full.
REQ-018 SHALL keep active unchanged at boundary with pend_full=0.
REQ-019 SHALL not apply a pair accepted in a boundary cycle until the following boundary, since pend_full was 0 in that cycle.
REQ-020 SHALL register led_out[i] = act_ptn[i] && (phase < act_duty); latency one clock from phase/active.
REQ-021 SHALL give duty 0 -> never on; duty 255 -> on 255 of 256 ticks.
REQ-022 SHALL register frame_pulse high for exactly the one cycle after every boundary, whether or not active changed.
REQ-023 SHALL never change active mid-frame; duty and pattern changes are glitch-free at frame edges only.

Reset
REQ-024 SHALL clear prescaler, phase, pending slot, pend_full, act_ptn, act_duty on RST, asynchronously.
REQ-025 SHALL drive led_out = 12'h000 and frame_pulse = 0 while RST is high; ptn_ready = 1 during and after reset.
REQ-026 SHALL ignore transfers in any cycle RST is high; a pending pair lost by reset mid-frame is not recovered.

Structure
REQ-027 SHALL take PWM_W default, LED count (4), and the 12-bit channel-order field positions from shared package rgb_pkg.
REQ-028 SHALL implement prescaler as sub-module m_tick_gen (parameter DIV, outputs one-cycle tick); phase, buffer, and output logic stay in m_rgb_pwm.
REQ-029 SHALL register all outputs except ptn_ready; no combinational path from ptn_valid to led_out.

Verification (PRESC_DIV=2, PWM_W=8: frame = 512 clocks)
REQ-030 SHALL check reset: assert RST mid-operation -> led_out=000, frame_pulse=0 immediately, ptn_ready=1; after release, first frame_pulse 512 clocks later.
REQ-031 SHALL check ptn 12'hFFF, duty 128 -> after next frame_pulse, led_out=FFF for 256 clocks, then 000 for 256 clocks, repeating.
REQ-032 SHALL check duty 0 -> led_out stays 000; duty 255 with ptn 12'h0F0 -> led_out=0F0 except 000 for exactly 2 clocks per frame.
REQ-033 SHALL check back-to-back: three pairs with valid held -> first accepted, ptn_ready=0 until boundary, second accepted cycle after frame applies first, third after next boundary.
REQ-034 SHALL check pair accepted exactly in boundary cycle -> applied only at the following boundary (512 clocks later).
REQ-035 SHALL check ptn_data changed while valid low -> no effect on active or led_out.
